// File: rtl/pc_stage_pipe_pkg.sv
// Shared types and constants for the PC fetch/stage pipeline.
// Every stage register carries a PC together with its valid bit.
package pc_pipe_pkg;

    localparam int PC_W = 8;

    localparam logic [PC_W-1:0] RESET_PC  = 8'h00;
    localparam logic [PC_W-1:0] BUBBLE_PC = 8'hFF;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            valid;
    } pc_stage_t;

    // Canonical empty stage; a bubble never carries a stale PC.
    function automatic pc_stage_t make_bubble(input logic [PC_W-1:0] bubble_pc);
        pc_stage_t s;
        s.pc    = bubble_pc;
        s.valid = 1'b0;
        return s;
    endfunction

endpackage

// File: rtl/pc_stage_pipe_if.sv
// Control inputs and per-stage PC outputs of the PC pipeline.
// The master side drives stall/branch; the slave side is the pipeline itself.
interface pc_stage_pipe_if;
    import pc_pipe_pkg::PC_W;

    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;

    logic [PC_W-1:0] PC_next;
    logic [PC_W-1:0] PC_nextID;
    logic [PC_W-1:0] PC_nextEX;
    logic [PC_W-1:0] PC_nextMEM;
    logic [PC_W-1:0] PC_nextWB;
    logic            valid_id;
    logic            valid_ex;
    logic            valid_mem;
    logic            valid_wb;

    modport master (
        output stall, branch_taken, branch_target,
        input  PC_next, PC_nextID, PC_nextEX, PC_nextMEM, PC_nextWB,
        input  valid_id, valid_ex, valid_mem, valid_wb
    );

    modport slave (
        input  stall, branch_taken, branch_target,
        output PC_next, PC_nextID, PC_nextEX, PC_nextMEM, PC_nextWB,
        output valid_id, valid_ex, valid_mem, valid_wb
    );

endinterface

// File: rtl/pc_stage_reg.sv
// One pipeline stage register holding {pc, valid}.
// Priority: load_bubble > hold > load_in; reset clears to a bubble.
module pc_stage_reg
    import pc_pipe_pkg::PC_W;
    import pc_pipe_pkg::pc_stage_t;
    import pc_pipe_pkg::make_bubble;
#(
    parameter logic [PC_W-1:0] BUBBLE_PC = pc_pipe_pkg::BUBBLE_PC
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      hold,
    input  logic      load_bubble,
    input  logic      load_in,
    input  pc_stage_t stage_i,
    output pc_stage_t stage_o
);

    pc_stage_t stage_d, stage_q;
    pc_stage_t in_clean;

    // An invalid upstream stage is re-canonicalised so no stale PC leaks through.
    always_comb begin
        in_clean = stage_i;
        if (!stage_i.valid) in_clean = make_bubble(BUBBLE_PC);
    end

    always_comb begin
        stage_d = stage_q;
        if (load_bubble)  stage_d = make_bubble(BUBBLE_PC);
        else if (hold)    stage_d = stage_q;
        else if (load_in) stage_d = in_clean;
    end

    always_ff @(posedge clk) begin
        if (rst) stage_q <= make_bubble(BUBBLE_PC);
        else     stage_q <= stage_d;
    end

    assign stage_o = stage_q;

endmodule

// File: rtl/pc_stage_pipe.sv
// Fetch-PC generator plus ID/EX/MEM/WB PC stage registers with valid bits.
// Handles sequential fetch, EX-resolved branch redirect with flush, and load-use stall.
module pc_stage_pipe
    import pc_pipe_pkg::PC_W;
    import pc_pipe_pkg::pc_stage_t;
#(
    parameter logic [PC_W-1:0] PC_INC    = 1,
    parameter logic [PC_W-1:0] RESET_PC  = pc_pipe_pkg::RESET_PC,
    parameter logic [PC_W-1:0] BUBBLE_PC = pc_pipe_pkg::BUBBLE_PC
) (
    input  logic            clk,
    input  logic            rst,
    pc_stage_pipe_if.slave  bus
);

    logic [PC_W-1:0] pc_next_d, pc_next_q;
    logic            redirect;
    logic            hold_front;
    pc_stage_t       fetch_s;
    pc_stage_t       id_s, ex_s, mem_s, wb_s;

    // A taken branch overrides a simultaneous stall.
    assign redirect   = bus.branch_taken;
    assign hold_front = bus.stall && !bus.branch_taken;

    always_comb begin
        pc_next_d = pc_next_q + PC_INC;
        if (redirect)        pc_next_d = bus.branch_target;
        else if (hold_front) pc_next_d = pc_next_q;
    end

    always_ff @(posedge clk) begin
        if (rst) pc_next_q <= RESET_PC;
        else     pc_next_q <= pc_next_d;
    end

    always_comb begin
        fetch_s.pc    = pc_next_q;
        fetch_s.valid = 1'b1;
    end

    pc_stage_reg #(.BUBBLE_PC(BUBBLE_PC)) u_id (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold_front),
        .load_bubble (redirect),
        .load_in     (1'b1),
        .stage_i     (fetch_s),
        .stage_o     (id_s)
    );

    // EX takes a bubble on stall (load-use) and on redirect (wrong-path flush).
    pc_stage_reg #(.BUBBLE_PC(BUBBLE_PC)) u_ex (
        .clk         (clk),
        .rst         (rst),
        .hold        (1'b0),
        .load_bubble (redirect || bus.stall),
        .load_in     (1'b1),
        .stage_i     (id_s),
        .stage_o     (ex_s)
    );

    pc_stage_reg #(.BUBBLE_PC(BUBBLE_PC)) u_mem (
        .clk         (clk),
        .rst         (rst),
        .hold        (1'b0),
        .load_bubble (1'b0),
        .load_in     (1'b1),
        .stage_i     (ex_s),
        .stage_o     (mem_s)
    );

    pc_stage_reg #(.BUBBLE_PC(BUBBLE_PC)) u_wb (
        .clk         (clk),
        .rst         (rst),
        .hold        (1'b0),
        .load_bubble (1'b0),
        .load_in     (1'b1),
        .stage_i     (mem_s),
        .stage_o     (wb_s)
    );

    assign bus.PC_next    = pc_next_q;
    assign bus.PC_nextID  = id_s.pc;
    assign bus.PC_nextEX  = ex_s.pc;
    assign bus.PC_nextMEM = mem_s.pc;
    assign bus.PC_nextWB  = wb_s.pc;
    assign bus.valid_id   = id_s.valid;
    assign bus.valid_ex   = ex_s.valid;
    assign bus.valid_mem  = mem_s.valid;
    assign bus.valid_wb   = wb_s.valid;

endmodule

// File: tb/tb_pc_stage_pipe.sv
// Directed test of pc_stage_pipe. Observed vector packs
// {PC_next, ID, EX, MEM, WB, valid_id, valid_ex, valid_mem, valid_wb}.
module tb_pc_stage_pipe;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    pc_stage_pipe_if bus ();

    pc_stage_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [43:0] obs;
    assign obs = {bus.PC_next, bus.PC_nextID, bus.PC_nextEX, bus.PC_nextMEM, bus.PC_nextWB,
                  bus.valid_id, bus.valid_ex, bus.valid_mem, bus.valid_wb};

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (obs !== 44'h00_FF_FF_FF_FF_0)
            $display("FAIL reset_state got=%h want=%h", obs, 44'h00_FF_FF_FF_FF_0);
        else passed++;
    endtask

    task automatic test_free_run();
        logic [43:0] exp_v [6];
        exp_v = '{44'h01_00_FF_FF_FF_8, 44'h02_01_00_FF_FF_C, 44'h03_02_01_00_FF_E,
                  44'h04_03_02_01_00_F, 44'h05_04_03_02_01_F, 44'h06_05_04_03_02_F};
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step();
            total++;
            if (obs !== exp_v[k])
                $display("FAIL free_run[%0d] got=%h want=%h", k + 1, obs, exp_v[k]);
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [43:0] exp_v [4];
        exp_v = '{44'hFE_FF_FF_01_00_3, 44'hFF_FE_FF_FF_01_9,
                  44'h00_FF_FE_FF_FF_C, 44'h01_00_FF_FE_FF_E};
        do_reset();
        run(3);
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'hFE;
        for (int k = 0; k < 4; k++) begin
            step();
            bus.branch_taken = 1'b0;
            total++;
            if (obs !== exp_v[k])
                $display("FAIL wrap[%0d] got=%h want=%h", k, obs, exp_v[k]);
            else passed++;
        end
    endtask

    task automatic test_stall();
        logic [43:0] exp_v [4];
        exp_v = '{44'h05_04_FF_03_02_B, 44'h05_04_FF_FF_03_9,
                  44'h06_05_04_FF_FF_C, 44'h07_06_05_04_FF_E};
        do_reset();
        run(5);
        bus.stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 1) bus.stall = 1'b0;
            total++;
            if (obs !== exp_v[k])
                $display("FAIL stall[%0d] got=%h want=%h", k, obs, exp_v[k]);
            else passed++;
        end
    endtask

    task automatic test_branch();
        logic [43:0] exp_v [3];
        exp_v = '{44'h40_FF_FF_03_02_3, 44'h41_40_FF_FF_03_9, 44'h42_41_40_FF_FF_C};
        do_reset();
        run(5);
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h40;
        for (int k = 0; k < 3; k++) begin
            step();
            bus.branch_taken = 1'b0;
            total++;
            if (obs !== exp_v[k])
                $display("FAIL branch[%0d] got=%h want=%h", k, obs, exp_v[k]);
            else passed++;
        end
    endtask

    task automatic test_branch_stall();
        logic [43:0] exp_v [2];
        exp_v = '{44'h20_FF_FF_03_02_3, 44'h21_20_FF_FF_03_9};
        do_reset();
        run(5);
        bus.branch_taken = 1'b1;
        bus.stall = 1'b1;
        bus.branch_target = 8'h20;
        for (int k = 0; k < 2; k++) begin
            step();
            bus.branch_taken = 1'b0;
            bus.stall = 1'b0;
            total++;
            if (obs !== exp_v[k])
                $display("FAIL branch_stall[%0d] got=%h want=%h", k, obs, exp_v[k]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run(10);
        total++;
        if (obs !== 44'h0A_09_08_07_06_F)
            $display("FAIL mid_pre got=%h want=%h", obs, 44'h0A_09_08_07_06_F);
        else passed++;
        // Reset must win over a concurrent branch and stall.
        rst = 1'b1;
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1;
        bus.branch_target = 8'h77;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (obs !== 44'h00_FF_FF_FF_FF_0)
                $display("FAIL mid_reset[%0d] got=%h want=%h", k, obs, 44'h00_FF_FF_FF_FF_0);
            else passed++;
        end
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        step();
        total++;
        if (obs !== 44'h01_00_FF_FF_FF_8)
            $display("FAIL mid_release got=%h want=%h", obs, 44'h01_00_FF_FF_FF_8);
        else passed++;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = '0;
        test_reset();
        test_free_run();
        test_wrap();
        test_stall();
        test_branch();
        test_branch_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_stage_pipe.md
Name: pc_stage_pipe

Overview:
- Upstream feeder of the PC state counter. Generates the fetch PC (PC_next) and carries each instruction's PC down the ID/EX/MEM/WB stage registers, with a valid bit per stage.
- Handles sequential increment, branch redirect (resolved in EX) with flush, and load-use stall with bubble insertion.
- Its five PC outputs drive the state counter's PC comparison inputs directly.

Parameters:
- PC_W, 8, PC width in bits.
- PC_INC, 1, sequential fetch increment.
- RESET_PC, 8'h00, fetch PC after reset.
- BUBBLE_PC, 8'hFF, PC value driven by an invalid (bubble) stage.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold IF and ID, inject a bubble into EX.
- branch_taken  input  1  branch in EX is taken; redirect fetch.
- branch_target  input  PC_W  redirect address, sampled when branch_taken=1.
- PC_next  output  PC_W  fetch-stage PC.
- PC_nextID  output  PC_W  PC of the instruction in ID.
- PC_nextEX  output  PC_W  PC of the instruction in EX.
- PC_nextMEM  output  PC_W  PC of the instruction in MEM.
- PC_nextWB  output  PC_W  PC of the instruction in WB.
- valid_id, valid_ex, valid_mem, valid_wb  output  1 each  stage holds a real instruction.

Behaviour:
- All outputs are registered. There is no combinational input-to-output path; all effects appear 1 cycle after the sampling edge.
- Reset (rst=1 at posedge), which overrides everything including mid-branch or mid-stall:
  - PC_next=RESET_PC.
  - PC_nextID/EX/MEM/WB=BUBBLE_PC.
  - All valid_*=0.
- While rst=1 the outputs hold their reset values. First fetch advance occurs at the first edge with rst=0.
- Priority per edge: rst > branch_taken > stall > normal.
- Normal (no stall, no branch):
  - PC_next <= PC_next+PC_INC, modulo 2^PC_W; 8'hFF+1 wraps to 8'h00.
  - ID <= PC_next, valid_id <= 1.
  - EX <= ID, MEM <= EX, WB <= MEM, each valid bit moving with its PC.
- Stall=1 (no branch):
  - PC_next and ID hold (value and valid).
  - EX <= BUBBLE_PC with valid_ex <= 0.
  - MEM <= EX and WB <= MEM advance.
  - Consecutive stall cycles keep inserting bubbles.
- Branch_taken=1, whether or not stall is asserted:
  - PC_next <= branch_target.
  - ID <= bubble. EX <= bubble (flushes the wrong-path instruction in ID).
  - MEM <= EX, so the branch itself retires normally; WB <= MEM.
  - A branch_taken while valid_ex=0 is a protocol error; it is not checked in RTL and behaves as above.
- A bubble stage always drives BUBBLE_PC and valid=0, never a stale PC.
- Wrap-around: no saturation anywhere; branch_target is taken verbatim.
- Downstream note: a fetch PC equal to BUBBLE_PC can alias bubble stages in the state counter. The valid_* outputs are provided for consumers that must disambiguate.

Decomposition:
- Shared package pc_pipe_pkg holds:
  - PC_W.
  - BUBBLE_PC and RESET_PC constants.
  - A pc_stage_t struct {pc, valid}.
- One sub-module, pc_stage_reg: a single stage register with controls hold, load_bubble and load_in. It is instantiated 4× for ID/EX/MEM/WB.
- Fetch-PC next-state logic stays in the top module.

Test Plan:
- Reset then 6 free-run cycles:
  - PC_next steps 00,01,…,06.
  - At cycle 5: ID=04, EX=03, MEM=02, WB=01, with valid_id..valid_wb all 1 by cycle 4.
- Wrap: force a branch to 8'hFE, then free-run. PC_next goes FE, FF, 00, 01; ID follows one cycle later with the same sequence.
- Stall for 2 cycles with PC_next=05, ID=04:
  - PC_next=05 and ID=04 hold.
  - EX shows BUBBLE_PC with valid_ex=0 for 2 cycles.
  - MEM and WB drain the previous EX/MEM contents.
  - After the stall, EX=04.
- Branch with EX=03, ID=04, PC_next=05, branch_target=8'h40:
  - Next cycle: PC_next=40, ID and EX are bubbles (valid=0), MEM=03.
  - Following cycle: ID=40, WB=03.
- Branch_taken and stall together with branch_target=8'h20: branch behaviour wins. PC_next=20, ID and EX are bubbles, and no hold occurs.
- Reset asserted mid-stream (PC_next=0A, all stages valid): the next edge gives PC_next=00, all stages BUBBLE_PC, all valid=0, and this holds for every cycle rst stays high.
